lut_sweep: RTL and testbench
============================

LUT_SWEEP -- requirements
Module: lut_sweep

Interface
REQ-001 SHALL provide parameter N_IN, default 4, number of function inputs (legal 2..8).
REQ-002 SHALL provide parameter TT_W, fixed at 2**N_IN, truth-table width (not overridable).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tt_wr  input  1  load truth table this cycle.
REQ-006 SHALL have port tt_data  input  TT_W  truth table; bit i = output for input vector i.
REQ-007 SHALL have port live_in  input  N_IN  live input vector, bit N_IN-1 = MSB (a in a,b,c,d ordering).
REQ-008 SHALL have port live_y  output  1  registered function value for live_in.
REQ-009 SHALL have port start  input  1  request exhaustive sweep.
REQ-010 SHALL have port busy  output  1  sweep in progress.
REQ-011 SHALL have port vec_valid  output  1  vec/vec_y valid this cycle.
REQ-012 SHALL have port vec  output  N_IN  current sweep vector.
REQ-013 SHALL have port vec_y  output  1  function value for vec.
REQ-014 SHALL have port done  output  1  one-cycle sweep-complete pulse.
REQ-015 SHALL have port ones_cnt  output  N_IN+1  count of vectors with y=1 in last sweep.

Function
REQ-016 SHALL hold the truth table in a TT_W-bit register; tt_wr=1 in IDLE loads tt_data at the clock edge.
REQ-017 SHALL ignore tt_wr while busy=1 (table unchanged).
REQ-018 SHALL drive live_y = table[live_in] registered, one-cycle latency, in every state.
REQ-019 SHALL use states IDLE, SWEEP, FIN.
REQ-020 SHALL, in IDLE with start=1, go to SWEEP, set vec=0, clear ones_cnt; busy=1 from the next cycle.
REQ-021 SHALL, in SWEEP, assert vec_valid=1 each cycle, vec_y=table[vec], increment vec by 1 per cycle.
REQ-022 SHALL add vec_y to ones_cnt at each SWEEP clock edge; width N_IN+1 so all-ones table never wraps.
REQ-023 SHALL, when vec = 2**N_IN-1 in SWEEP, go to FIN at the next edge; vec does not wrap to 0 while valid.
REQ-024 SHALL, in FIN, assert done=1 for exactly one cycle, busy=0, vec_valid=0, ones_cnt final; then go to IDLE.
REQ-025 SHALL result in: start accepted at edge 0 -> vec_valid cycles 1..2**N_IN, done in cycle 2**N_IN+1.
REQ-026 SHALL ignore start while in SWEEP or FIN; start in the IDLE cycle after FIN begins a new sweep.
REQ-027 SHALL give tt_wr priority over start when both are asserted in IDLE; the sweep uses the newly loaded table.
REQ-028 SHALL hold ones_cnt stable from FIN until the next accepted start.
REQ-029 SHALL hold vec and vec_y at their last values when vec_valid=0; consumers gate on vec_valid.

Reset
REQ-030 SHALL, on rst=1 at an edge, force IDLE, truth table=0, live_y=0, busy=0, vec_valid=0, vec=0, vec_y=0, done=0, ones_cnt=0.
REQ-031 SHALL abort a sweep in progress on rst with no done pulse; rst overrides start and tt_wr.

Configuration
REQ-032 SHALL, with macro LUT_SWEEP_ABORT_EN defined, add port abort input 1: abort=1 in SWEEP -> IDLE at next edge, no done, ones_cnt holds partial count.
REQ-033 SHALL, without LUT_SWEEP_ABORT_EN, have no abort port; a sweep always runs to FIN.

Verification
REQ-034 SHALL cover: N_IN=4, load 16'hA5C3, start -> vec 0..15 over 16 valid cycles, vec_y matches table bits, done in cycle 17, ones_cnt=8.
REQ-035 SHALL cover: table 16'hFFFF then 16'h0000 sweeps -> ones_cnt=16 (no wrap), then 0.
REQ-036 SHALL cover: live_in stepped 0..15 as in the 4-input exhaustive sweep, table 16'h8000 -> live_y=1 only one cycle after live_in=4'b1111.
REQ-037 SHALL cover: tt_wr and start during SWEEP -> table and ones_cnt unaffected; tt_wr+start together in IDLE -> sweep uses new table.
REQ-038 SHALL cover: rst at vec=7 -> next cycle all outputs 0, IDLE, no done; with LUT_SWEEP_ABORT_EN, abort at vec=7 on 16'hFFFF -> no done, ones_cnt=7 or 8 per edge timing, held.

Source files
------------

// File: rtl/lut_sweep.sv
// lut_sweep: programmable N_IN-input Boolean function held as a truth table.
//
// The table is loaded while idle. It is evaluated two ways:
//   * live path  : live_y is the table entry for live_in, one cycle later.
//   * sweep path : on start, every input vector 0 .. 2**N_IN-1 is produced
//                  once per cycle on vec/vec_y (qualified by vec_valid).
//                  The count of ones is accumulated and reported on ones_cnt.
//                  A one-cycle done pulse follows the sweep.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   tt_wr     in   load tt_data into the table (IDLE only)
//   tt_data   in   TT_W  truth table, bit i = output for input vector i
//   live_in   in   N_IN  live input vector (MSB = first variable)
//   live_y    out  registered table[live_in]
//   start     in   request an exhaustive sweep (IDLE only)
//   abort     in   only with LUT_SWEEP_ABORT_EN: leave SWEEP without done
//   busy      out  sweep in progress
//   vec_valid out  vec/vec_y valid this cycle
//   vec       out  N_IN  current sweep vector (holds when not valid)
//   vec_y     out  table[vec] (holds when not valid)
//   done      out  one-cycle sweep-complete pulse
//   ones_cnt  out  N_IN+1  number of ones seen in the last sweep
//
// Optional feature macro: LUT_SWEEP_ABORT_EN (adds the abort port).
module lut_sweep #(
  parameter  int N_IN = 4,
  localparam int TT_W = 2**N_IN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tt_wr,
  input  logic [TT_W-1:0]   tt_data,
  input  logic [N_IN-1:0]   live_in,
  output logic              live_y,
  input  logic              start,
`ifdef LUT_SWEEP_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              vec_valid,
  output logic [N_IN-1:0]   vec,
  output logic              vec_y,
  output logic              done,
  output logic [N_IN:0]     ones_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [N_IN-1:0] VEC_ZERO = '0;
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};

  state_t            state_q,     state_d;
  logic [TT_W-1:0]   table_q,     table_d;
  logic              live_y_q,    live_y_d;
  logic              busy_q,      busy_d;
  logic              vec_valid_q, vec_valid_d;
  logic [N_IN-1:0]   vec_q,       vec_d;
  logic              vec_y_q,     vec_y_d;
  logic              done_q,      done_d;
  logic [N_IN:0]     ones_q,      ones_d;
  logic              abort_s;

`ifdef LUT_SWEEP_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Next-state and next-output computation for the sweep controller
  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    vec_d       = vec_q;
    vec_y_d     = vec_y_q;
    ones_d      = ones_q;
    busy_d      = 1'b0;
    vec_valid_d = 1'b0;
    done_d      = 1'b0;
    live_y_d    = table_q[live_in];

    case (state_q)
      IDLE: begin
        if (tt_wr) begin
          table_d = tt_data;
        end else begin
          table_d = table_q;
        end
        if (start) begin
          // table_d is used so a same-cycle load feeds the first vector
          state_d     = SWEEP;
          vec_d       = VEC_ZERO;
          vec_y_d     = table_d[VEC_ZERO];
          ones_d      = '0;
          busy_d      = 1'b1;
          vec_valid_d = 1'b1;
        end else begin
          state_d     = IDLE;
        end
      end
      SWEEP: begin
        // The vector on the outputs this cycle is counted at this edge
        ones_d = ones_q + (N_IN+1)'(vec_y_q);
        if (abort_s) begin
          state_d = IDLE;
        end else if (vec_q == VEC_LAST) begin
          // vec/vec_y hold their last values rather than wrapping
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          vec_d       = vec_q + VEC_ONE;
          vec_y_d     = table_q[vec_d];
          busy_d      = 1'b1;
          vec_valid_d = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      table_q     <= '0;
      live_y_q    <= 1'b0;
      busy_q      <= 1'b0;
      vec_valid_q <= 1'b0;
      vec_q       <= '0;
      vec_y_q     <= 1'b0;
      done_q      <= 1'b0;
      ones_q      <= '0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      live_y_q    <= live_y_d;
      busy_q      <= busy_d;
      vec_valid_q <= vec_valid_d;
      vec_q       <= vec_d;
      vec_y_q     <= vec_y_d;
      done_q      <= done_d;
      ones_q      <= ones_d;
    end
  end

  assign live_y    = live_y_q;
  assign busy      = busy_q;
  assign vec_valid = vec_valid_q;
  assign vec       = vec_q;
  assign vec_y     = vec_y_q;
  assign done      = done_q;
  assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_lut_sweep.sv
// Self-checking bench for lut_sweep with N_IN = 4.
module tb_lut_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        tt_wr;
  logic [15:0] tt_data;
  logic [3:0]  live_in;
  logic        live_y;
  logic        start;
  logic        abort;
  logic        busy;
  logic        vec_valid;
  logic [3:0]  vec;
  logic        vec_y;
  logic        done;
  logic [4:0]  ones_cnt;

  typedef struct packed {
    logic [3:0] v;
    logic       y;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] tt_m;
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  lut_sweep #(.N_IN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .tt_wr     (tt_wr),
    .tt_data   (tt_data),
    .live_in   (live_in),
    .live_y    (live_y),
    .start     (start),
`ifdef LUT_SWEEP_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .vec_valid (vec_valid),
    .vec       (vec),
    .vec_y     (vec_y),
    .done      (done),
    .ones_cnt  (ones_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_valid"}, 32'(vec_valid), 32'd0);
    chk({tag, "_vec"},   32'(vec),       32'd0);
    chk({tag, "_vecy"},  32'(vec_y),     32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
    chk({tag, "_ones"},  32'(ones_cnt),  32'd0);
    chk({tag, "_livey"}, 32'(live_y),    32'd0);
  endtask

  // Full sweep; optional same-cycle table load and optional mid-sweep
  // tt_wr/start injection that must be ignored.
  task automatic sweep(input logic [15:0] new_tt, input bit load, input bit inject);
    exp_t e;
    int   run_cnt;
    if (load) begin
      tt_wr   = 1'b1;
      tt_data = new_tt;
      tt_m    = new_tt;
    end
    for (int i = 0; i < 16; i++) begin
      e.v = 4'(i);
      e.y = tt_m[i];
      sb_q.push_back(e);
    end
    start = 1'b1;
    step();
    start   = 1'b0;
    tt_wr   = 1'b0;
    run_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      chk("sw_valid", 32'(vec_valid), 32'd1);
      chk("sw_busy",  32'(busy),      32'd1);
      chk("sw_done",  32'(done),      32'd0);
      chk("sw_ones_run", 32'(ones_cnt), 32'(run_cnt));
      if (vec_valid) begin
        if (sb_q.size() == 0) begin
          chk("sw_sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sw_vec",  32'(vec),   32'(e.v));
          chk("sw_vecy", 32'(vec_y), 32'(e.y));
          run_cnt += int'(e.y);
        end
      end
      if (inject && c == 5) begin
        tt_wr   = 1'b1;
        tt_data = ~tt_m;
        start   = 1'b1;
      end else begin
        tt_wr   = 1'b0;
        start   = 1'b0;
      end
      step();
    end
    chk("fin_done",  32'(done),      32'd1);
    chk("fin_busy",  32'(busy),      32'd0);
    chk("fin_valid", 32'(vec_valid), 32'd0);
    chk("fin_ones",  32'(ones_cnt),  32'($countones(tt_m)));
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    step();
    chk("post_done", 32'(done),     32'd0);
    chk("post_ones", 32'(ones_cnt), 32'($countones(tt_m)));
  endtask

  initial begin
    rst     = 1'b1;
    tt_wr   = 1'b0;
    tt_data = 16'h0000;
    live_in = 4'h0;
    start   = 1'b0;
    abort   = 1'b0;
    tt_m    = 16'h0000;
    step();
    step();
    chk_idle_zero("reset");
    rst = 1'b0;
    step();

    // Mixed table, then all-ones (no counter wrap) and all-zeros
    sweep(16'hA5C3, 1'b1, 1'b0);
    sweep(16'hFFFF, 1'b1, 1'b0);
    sweep(16'h0000, 1'b1, 1'b0);
    sweep(16'hA5C3, 1'b1, 1'b0);

    // Count and last vector hold while idle
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_ones", 32'(ones_cnt), 32'd8);
      chk("hold_vec",  32'(vec),      32'd15);
      chk("hold_vecy", 32'(vec_y),    32'(tt_m[15]));
    end

    // Live path: only input 1111 selects a one
    tt_wr   = 1'b1;
    tt_data = 16'h8000;
    tt_m    = 16'h8000;
    step();
    tt_wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      live_in = 4'(i);
      step();
      chk("live_y", 32'(live_y), (i == 15) ? 32'd1 : 32'd0);
    end

    // tt_wr/start injected mid-sweep are ignored; a re-sweep proves the table
    sweep(16'h0000, 1'b0, 1'b1);
    sweep(16'h0000, 1'b0, 1'b0);

    // start held high: ignored in FIN, accepted in the following IDLE cycle
    start = 1'b1;
    step();
    for (int c = 1; c < 17; c++) step();
    chk("b2b_done",   32'(done),      32'd1);
    step();
    chk("b2b_idle_busy",  32'(busy),      32'd0);
    chk("b2b_idle_valid", 32'(vec_valid), 32'd0);
    chk("b2b_idle_done",  32'(done),      32'd0);
    step();
    start = 1'b0;
    chk("b2b_rest_busy", 32'(busy), 32'd1);
    chk("b2b_rest_vec",  32'(vec),  32'd0);
    for (int c = 2; c <= 17; c++) step();
    chk("b2b_done2", 32'(done), 32'd1);
    step();

    // Reset during a sweep at vec=7
    tt_wr   = 1'b1;
    tt_data = 16'hFFFF;
    tt_m    = 16'hFFFF;
    step();
    tt_wr = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 8; c++) step();
    chk("rst_pre_vec", 32'(vec), 32'd7);
    rst     = 1'b1;
    live_in = 4'hF;
    step();
    rst = 1'b0;
    chk_idle_zero("rst_mid");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_after_done",  32'(done),   32'd0);
      chk("rst_after_busy",  32'(busy),   32'd0);
      chk("rst_after_livey", 32'(live_y), 32'd0);
    end

`ifdef LUT_SWEEP_ABORT_EN
    // Abort at vec=7 on an all-ones table: vectors 0..7 counted, no done
    tt_wr   = 1'b1;
    tt_data = 16'hFFFF;
    step();
    tt_wr = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 8; c++) step();
    chk("abort_pre_vec", 32'(vec), 32'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_valid", 32'(vec_valid), 32'd0);
    chk("abort_done",  32'(done),      32'd0);
    chk("abort_ones",  32'(ones_cnt),  32'd8);
    step();
    chk("abort_done2", 32'(done),     32'd0);
    chk("abort_hold",  32'(ones_cnt), 32'd8);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
